// File: rtl/race_pkg.sv
// race_pkg: shared constants for the race datapath.
// Heading codes, screen size, colours, default start position.
package race_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_START_X = 10;
  localparam int DEF_START_Y = 58;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_CAR   = 3'b100;

  typedef enum logic [1:0] {
    HEAD_E = 2'd0,
    HEAD_S = 2'd1,
    HEAD_W = 2'd2,
    HEAD_N = 2'd3
  } heading_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_CAR,
    REQ_OVER,
    REQ_FIX
  } req_e;

  // Add d to v and clamp into [0, hi].
  function automatic int sat_add(
    input int v,
    input int d,
    input int hi
  );
    int s;
    s = v + d;
    if (s < 0) s = 0;
    if (s > hi) s = hi;
    return s;
  endfunction

endpackage

// File: rtl/car_sprite_datapath_if.sv
// car_sprite_datapath_if: pixel bus to the VGA adapter and background ROM.
// master: bg_addr/x/y/colour/pix_valid out, bg_colour in; slave mirrors.
interface car_sprite_datapath_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);

  logic [X_W+Y_W-1:0] bg_addr;
  logic [2:0]         bg_colour;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [2:0]         colour;
  logic               pix_valid;

  modport master (
    output bg_addr,
    output x,
    output y,
    output colour,
    output pix_valid,
    input  bg_colour
  );

  modport slave (
    input  bg_addr,
    input  x,
    input  y,
    input  colour,
    input  pix_valid,
    output bg_colour
  );

endinterface

// File: rtl/sprite_sweep_counter.sv
// sprite_sweep_counter: raster dx (inner) / dy (outer) sprite counter.
// In: Clock, Reset, clear, hold. Out: dx, dy, last (stops at last).
module sprite_sweep_counter #(
  parameter int CAR_W = 4,
  parameter int CAR_H = 4,
  parameter int DX_W  = 2,
  parameter int DY_W  = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            clear,
  input  logic            hold,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic            last
);

  logic [DX_W-1:0] dx_q, dx_d;
  logic [DY_W-1:0] dy_q, dy_d;
  logic            dx_end;
  logic            dy_end;

  assign dx_end = (dx_q == DX_W'(CAR_W - 1));
  assign dy_end = (dy_q == DY_W'(CAR_H - 1));
  assign last   = dx_end & dy_end;

  // Parks on the last pixel so a held request sees a frozen count.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = '0;
      dy_d = '0;
    end else if (!hold && !last) begin
      if (dx_end) begin
        dx_d = '0;
        dy_d = dy_q + DY_W'(1);
      end else begin
        dx_d = dx_q + DX_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx = dx_q;
  assign dy = dy_q;

endmodule

// File: rtl/car_sprite_datapath.sv
// car_sprite_datapath: car position/heading, moves, and draw/over/fix sweeps.
// In: Clock, Reset, FSM controls, player inputs. Out: pixel bus, Done flags.
module car_sprite_datapath
  import race_pkg::*;
#(
  parameter int         CAR_W      = 4,
  parameter int         CAR_H      = 4,
  parameter int         X_W        = 8,
  parameter int         Y_W        = 7,
  parameter int         START_X    = DEF_START_X,
  parameter int         START_Y    = DEF_START_Y,
  parameter int         STEP       = 1,
  parameter logic [2:0] CAR_COLOUR = COL_CAR
) (
  input  logic Clock,
  input  logic Reset,
  input  logic set_reset_signals,
  input  logic start_race,
  input  logic draw_car,
  input  logic draw_over_car,
  input  logic draw_fix_car,
  input  logic move,
  input  logic forward,
  input  logic left,
  input  logic right,
  car_sprite_datapath_if.master bus,
  output logic DoneDrawCar,
  output logic DoneDrawOverCar,
  output logic DoneFixCar
);

  localparam int DX_W  = (CAR_W > 1) ? $clog2(CAR_W) : 1;
  localparam int DY_W  = (CAR_H > 1) ? $clog2(CAR_H) : 1;
  localparam int X_MAX = SCREEN_W - CAR_W;
  localparam int Y_MAX = SCREEN_H - CAR_H;

  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d;
  logic [X_W-1:0] prev_x_q, prev_x_d;
  logic [Y_W-1:0] prev_y_q, prev_y_d;
  heading_e       heading_q, heading_d;

  logic           done_car_q, done_car_d;
  logic           done_over_q, done_over_d;
  logic           done_fix_q, done_fix_d;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0]     col_q, col_d;
  logic           use_bg_q, use_bg_d;
  logic           valid_q, valid_d;

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            last;
  logic            reload;
  logic            emit;
  logic            done_act;
  req_e            req;
  logic [X_W-1:0]  pix_x;
  logic [Y_W-1:0]  pix_y;

  assign reload = set_reset_signals | start_race;

  always_comb begin
    req = REQ_NONE;
    if (draw_fix_car)       req = REQ_FIX;
    else if (draw_over_car) req = REQ_OVER;
    else if (draw_car)      req = REQ_CAR;
  end

  always_comb begin
    done_act = 1'b0;
    unique case (req)
      REQ_CAR:  done_act = done_car_q;
      REQ_OVER: done_act = done_over_q;
      REQ_FIX:  done_act = done_fix_q;
      default:  done_act = 1'b0;
    endcase
  end

  assign emit = (req != REQ_NONE) & ~done_act & ~reload;

  sprite_sweep_counter #(
    .CAR_W (CAR_W),
    .CAR_H (CAR_H),
    .DX_W  (DX_W),
    .DY_W  (DY_W)
  ) u_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .clear (reload | (req == REQ_NONE)),
    .hold  (~emit),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

  assign pix_x = pos_x_q + X_W'(dx);
  assign pix_y = pos_y_q + Y_W'(dy);

  assign bus.bg_addr = {pix_y, pix_x};

  // Position, heading and the fix-sweep rollback.
  always_comb begin
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    prev_x_d  = prev_x_q;
    prev_y_d  = prev_y_q;
    heading_d = heading_q;
    if (reload) begin
      pos_x_d   = X_W'(START_X);
      pos_y_d   = Y_W'(START_Y);
      prev_x_d  = X_W'(START_X);
      prev_y_d  = Y_W'(START_Y);
      heading_d = HEAD_E;
    end else begin
      if (move) begin
        if (forward) begin
          prev_x_d = pos_x_q;
          prev_y_d = pos_y_q;
          unique case (heading_q)
            HEAD_E: pos_x_d = X_W'(sat_add(int'(pos_x_q), STEP, X_MAX));
            HEAD_S: pos_y_d = Y_W'(sat_add(int'(pos_y_q), STEP, Y_MAX));
            HEAD_W: pos_x_d = X_W'(sat_add(int'(pos_x_q), -STEP, X_MAX));
            HEAD_N: pos_y_d = Y_W'(sat_add(int'(pos_y_q), -STEP, Y_MAX));
            default: ;
          endcase
        end else if (left) begin
          heading_d = heading_e'(heading_q - 2'd1);
        end else if (right) begin
          heading_d = heading_e'(heading_q + 2'd1);
        end
      end
      // A completed fix sweep undoes the move that hit the wall.
      if (emit && req == REQ_FIX && last) begin
        pos_x_d = prev_x_q;
        pos_y_d = prev_y_q;
      end
    end
  end

  // Done flags: set with the last pixel, held while the request stays up.
  always_comb begin
    done_car_d  = done_car_q;
    done_over_d = done_over_q;
    done_fix_d  = done_fix_q;
    if (emit && last) begin
      unique case (req)
        REQ_CAR:  done_car_d  = 1'b1;
        REQ_OVER: done_over_d = 1'b1;
        REQ_FIX:  done_fix_d  = 1'b1;
        default:  ;
      endcase
    end
    if (reload || !draw_car)      done_car_d  = 1'b0;
    if (reload || !draw_over_car) done_over_d = 1'b0;
    if (reload || !draw_fix_car)  done_fix_d  = 1'b0;
  end

  // Output stage; background colour joins one cycle later from the ROM.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    valid_d  = emit;
    use_bg_d = emit & (req != REQ_CAR);
    col_d    = COL_BLACK;
    if (emit) begin
      x_d = pix_x;
      y_d = pix_y;
      if (req == REQ_CAR) col_d = CAR_COLOUR;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pos_x_q     <= X_W'(START_X);
      pos_y_q     <= Y_W'(START_Y);
      prev_x_q    <= X_W'(START_X);
      prev_y_q    <= Y_W'(START_Y);
      heading_q   <= HEAD_E;
      done_car_q  <= 1'b0;
      done_over_q <= 1'b0;
      done_fix_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= COL_BLACK;
      use_bg_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      heading_q   <= heading_d;
      done_car_q  <= done_car_d;
      done_over_q <= done_over_d;
      done_fix_q  <= done_fix_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      use_bg_q    <= use_bg_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.pix_valid = valid_q;
  assign bus.colour    = use_bg_q ? bus.bg_colour : col_q;

  assign DoneDrawCar     = done_car_q;
  assign DoneDrawOverCar = done_over_q;
  assign DoneFixCar      = done_fix_q;

endmodule

// File: tb/tb_car_sprite_datapath.sv
// tb_car_sprite_datapath: directed bench for car_sprite_datapath.
// Models a 1-cycle background ROM and checks sweeps, moves and resets.
module tb_car_sprite_datapath;
  import race_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic set_reset_signals = 1'b0;
  logic start_race = 1'b0;
  logic draw_car = 1'b0;
  logic draw_over_car = 1'b0;
  logic draw_fix_car = 1'b0;
  logic move = 1'b0;
  logic forward = 1'b0;
  logic left = 1'b0;
  logic right = 1'b0;
  logic DoneDrawCar, DoneDrawOverCar, DoneFixCar;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rom_mode = 0;

  car_sprite_datapath_if bus ();

  car_sprite_datapath dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .set_reset_signals (set_reset_signals),
    .start_race        (start_race),
    .draw_car          (draw_car),
    .draw_over_car     (draw_over_car),
    .draw_fix_car      (draw_fix_car),
    .move              (move),
    .forward           (forward),
    .left              (left),
    .right             (right),
    .bus               (bus),
    .DoneDrawCar       (DoneDrawCar),
    .DoneDrawOverCar   (DoneDrawOverCar),
    .DoneFixCar        (DoneFixCar)
  );

  always #5 Clock = ~Clock;

  // Background ROM: constant 3'b011, or the low 3 bits of x.
  always @(posedge Clock)
    bus.bg_colour <= (rom_mode == 0) ? 3'b011 : bus.bg_addr[2:0];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic hold_move(input logic f, input logic l,
                           input logic r, input int n);
    move = 1'b1; forward = f; left = l; right = r;
    repeat (n) tick();
    move = 1'b0; forward = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic pulse_start();
    start_race = 1'b1;
    tick();
    start_race = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    total_cnt++;
    if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== 19'd0)
      $display("FAIL reset_pix got=%h want=0",
               {bus.pix_valid, bus.x, bus.y, bus.colour});
    else pass_cnt++;
    total_cnt++;
    if (bus.bg_addr !== {7'd58, 8'd10})
      $display("FAIL reset_addr got=%h want=%h", bus.bg_addr, {7'd58, 8'd10});
    else pass_cnt++;
    total_cnt++;
    if ({DoneDrawCar, DoneDrawOverCar, DoneFixCar} !== 3'b000)
      $display("FAIL reset_done got=%b want=000",
               {DoneDrawCar, DoneDrawOverCar, DoneFixCar});
    else pass_cnt++;
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_draw_car();
    logic [18:0] exp;
    draw_car = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge Clock);
      total_cnt++;
      if (c >= 1 && c <= 16) begin
        exp = {1'b1, 8'(10 + (c - 1) % 4), 7'(58 + (c - 1) / 4), 3'b100};
        if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== exp)
          $display("FAIL car_pix c=%0d got=%h want=%h", c,
                   {bus.pix_valid, bus.x, bus.y, bus.colour}, exp);
        else pass_cnt++;
      end else begin
        if (bus.pix_valid !== 1'b0)
          $display("FAIL car_idle c=%0d got=%b want=0", c, bus.pix_valid);
        else pass_cnt++;
      end
      total_cnt++;
      if ({DoneDrawCar, DoneDrawOverCar, DoneFixCar} !== {c >= 16, 2'b00})
        $display("FAIL car_done c=%0d got=%b want=%b", c,
                 {DoneDrawCar, DoneDrawOverCar, DoneFixCar}, {c >= 16, 2'b00});
      else pass_cnt++;
      tick();
    end
    draw_car = 1'b0;
    @(negedge Clock);
    total_cnt++;
    if (DoneDrawCar !== 1'b1)
      $display("FAIL car_done_hold got=%b want=1", DoneDrawCar);
    else pass_cnt++;
    tick();
    @(negedge Clock);
    total_cnt++;
    if (DoneDrawCar !== 1'b0)
      $display("FAIL car_done_clear got=%b want=0", DoneDrawCar);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_moves();
    // {forward,left,right}, expected x, expected y after the move
    logic [2:0] cmd [10] = '{3'b100, 3'b010, 3'b100, 3'b001, 3'b100,
                             3'b011, 3'b100, 3'b001, 3'b110, 3'b000};
    int ex [10] = '{11, 11, 11, 11, 12, 12, 12, 12, 13, 13};
    int ey [10] = '{58, 58, 57, 57, 57, 57, 56, 56, 56, 56};
    for (int i = 0; i < 10; i++) begin
      hold_move(cmd[i][2], cmd[i][1], cmd[i][0], 1);
      @(negedge Clock);
      total_cnt++;
      if (bus.bg_addr !== {7'(ey[i]), 8'(ex[i])})
        $display("FAIL move%0d got=%h want=%h", i, bus.bg_addr,
                 {7'(ey[i]), 8'(ex[i])});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_draw_over();
    logic [18:0] exp;
    logic [14:0] ea;
    rom_mode = 0;
    draw_over_car = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge Clock);
      if (c <= 15) begin
        ea = {7'(56 + c / 4), 8'(13 + c % 4)};
        total_cnt++;
        if (bus.bg_addr !== ea)
          $display("FAIL over_addr c=%0d got=%h want=%h", c, bus.bg_addr, ea);
        else pass_cnt++;
      end
      total_cnt++;
      if (c >= 1 && c <= 16) begin
        exp = {1'b1, 8'(13 + (c - 1) % 4), 7'(56 + (c - 1) / 4), 3'b011};
        if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== exp)
          $display("FAIL over_pix c=%0d got=%h want=%h", c,
                   {bus.pix_valid, bus.x, bus.y, bus.colour}, exp);
        else pass_cnt++;
      end else begin
        if (bus.pix_valid !== 1'b0)
          $display("FAIL over_idle c=%0d got=%b want=0", c, bus.pix_valid);
        else pass_cnt++;
      end
      total_cnt++;
      if ({DoneDrawCar, DoneDrawOverCar, DoneFixCar} !== {1'b0, c >= 16, 1'b0})
        $display("FAIL over_done c=%0d got=%b want=%b", c,
                 {DoneDrawCar, DoneDrawOverCar, DoneFixCar},
                 {1'b0, c >= 16, 1'b0});
      else pass_cnt++;
      tick();
    end
    draw_over_car = 1'b0;
    tick();
    @(negedge Clock);
    total_cnt++;
    if (DoneDrawOverCar !== 1'b0)
      $display("FAIL over_done_clear got=%b want=0", DoneDrawOverCar);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_saturation();
    pulse_start();
    @(negedge Clock);
    total_cnt++;
    if (bus.bg_addr !== {7'd58, 8'd10})
      $display("FAIL reload_addr got=%h want=%h", bus.bg_addr, {7'd58, 8'd10});
    else pass_cnt++;
    tick();
    hold_move(1'b1, 1'b0, 1'b0, 146);
    @(negedge Clock);
    total_cnt++;
    if (bus.bg_addr !== {7'd58, 8'd156})
      $display("FAIL sat_x_reach got=%h want=%h", bus.bg_addr, {7'd58, 8'd156});
    else pass_cnt++;
    tick();
    hold_move(1'b1, 1'b0, 1'b0, 1);
    @(negedge Clock);
    total_cnt++;
    if (bus.bg_addr !== {7'd58, 8'd156})
      $display("FAIL sat_x_hold got=%h want=%h", bus.bg_addr, {7'd58, 8'd156});
    else pass_cnt++;
    tick();
    hold_move(1'b0, 1'b1, 1'b0, 1);
    hold_move(1'b1, 1'b0, 1'b0, 60);
    @(negedge Clock);
    total_cnt++;
    if (bus.bg_addr !== {7'd0, 8'd156})
      $display("FAIL sat_y_zero got=%h want=%h", bus.bg_addr, {7'd0, 8'd156});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fix();
    logic [18:0] exp;
    logic [7:0]  ex;
    pulse_start();
    hold_move(1'b1, 1'b0, 1'b0, 10);
    hold_move(1'b1, 1'b0, 1'b0, 1);
    @(negedge Clock);
    total_cnt++;
    if (bus.bg_addr !== {7'd58, 8'd21})
      $display("FAIL fix_pre got=%h want=%h", bus.bg_addr, {7'd58, 8'd21});
    else pass_cnt++;
    tick();
    rom_mode = 1;
    draw_fix_car = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge Clock);
      total_cnt++;
      if (c >= 1 && c <= 16) begin
        ex  = 8'(21 + (c - 1) % 4);
        exp = {1'b1, ex, 7'(58 + (c - 1) / 4), ex[2:0]};
        if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== exp)
          $display("FAIL fix_pix c=%0d got=%h want=%h", c,
                   {bus.pix_valid, bus.x, bus.y, bus.colour}, exp);
        else pass_cnt++;
      end else begin
        if (bus.pix_valid !== 1'b0)
          $display("FAIL fix_idle c=%0d got=%b want=0", c, bus.pix_valid);
        else pass_cnt++;
      end
      total_cnt++;
      if ({DoneDrawCar, DoneDrawOverCar, DoneFixCar} !== {2'b00, c >= 16})
        $display("FAIL fix_done c=%0d got=%b want=%b", c,
                 {DoneDrawCar, DoneDrawOverCar, DoneFixCar}, {2'b00, c >= 16});
      else pass_cnt++;
      tick();
    end
    draw_fix_car = 1'b0;
    tick();
    @(negedge Clock);
    total_cnt++;
    if ({DoneFixCar, bus.bg_addr} !== {1'b0, 7'd58, 8'd20})
      $display("FAIL fix_restore got=%h want=%h",
               {DoneFixCar, bus.bg_addr}, {1'b0, 7'd58, 8'd20});
    else pass_cnt++;
    tick();
    hold_move(1'b1, 1'b0, 1'b0, 1);
    @(negedge Clock);
    total_cnt++;
    if (bus.bg_addr !== {7'd58, 8'd21})
      $display("FAIL fix_heading got=%h want=%h", bus.bg_addr, {7'd58, 8'd21});
    else pass_cnt++;
    tick();
    rom_mode = 0;
  endtask

  task automatic test_abort();
    logic [18:0] exp;
    draw_car = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) draw_car = 1'b0;
      @(negedge Clock);
      total_cnt++;
      if (c >= 1 && c <= 5) begin
        exp = {1'b1, 8'(21 + (c - 1) % 4), 7'(58 + (c - 1) / 4), 3'b100};
        if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== exp)
          $display("FAIL abort_pix c=%0d got=%h want=%h", c,
                   {bus.pix_valid, bus.x, bus.y, bus.colour}, exp);
        else pass_cnt++;
      end else begin
        if (bus.pix_valid !== 1'b0)
          $display("FAIL abort_idle c=%0d got=%b want=0", c, bus.pix_valid);
        else pass_cnt++;
      end
      total_cnt++;
      if ({DoneDrawCar, DoneDrawOverCar, DoneFixCar} !== 3'b000)
        $display("FAIL abort_done c=%0d got=%b want=000", c,
                 {DoneDrawCar, DoneDrawOverCar, DoneFixCar});
      else pass_cnt++;
      tick();
    end
    draw_car = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      total_cnt++;
      if (c == 0) begin
        if (bus.bg_addr !== {7'd58, 8'd21})
          $display("FAIL restart_addr got=%h want=%h", bus.bg_addr,
                   {7'd58, 8'd21});
        else pass_cnt++;
      end else begin
        exp = {1'b1, 8'(21 + c - 1), 7'd58, 3'b100};
        if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== exp)
          $display("FAIL restart_pix c=%0d got=%h want=%h", c,
                   {bus.pix_valid, bus.x, bus.y, bus.colour}, exp);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.pix_valid, bus.x, bus.y, bus.colour} !== 19'd0)
      $display("FAIL rst_mid_pix got=%h want=0",
               {bus.pix_valid, bus.x, bus.y, bus.colour});
    else pass_cnt++;
    total_cnt++;
    if ({DoneDrawCar, DoneDrawOverCar, DoneFixCar, bus.bg_addr} !==
        {3'b000, 7'd58, 8'd10})
      $display("FAIL rst_mid_state got=%h want=%h",
               {DoneDrawCar, DoneDrawOverCar, DoneFixCar, bus.bg_addr},
               {3'b000, 7'd58, 8'd10});
    else pass_cnt++;
    draw_car = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    tick();
    @(negedge Clock);
    total_cnt++;
    if ({bus.pix_valid, bus.bg_addr} !== {1'b0, 7'd58, 8'd10})
      $display("FAIL rst_after got=%h want=%h", {bus.pix_valid, bus.bg_addr},
               {1'b0, 7'd58, 8'd10});
    else pass_cnt++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_draw_car();
    test_moves();
    test_draw_over();
    test_saturation();
    test_fix();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
